// File: rtl/magia_stdio_arbiter.sv
// Line-atomic merge of per-tile stdout streams into one serial stream.
// Define MAGIA_STDIO_TIMESTAMP_EN to add the cycle-stamped out_timestamp_o port.
module magia_stdio_arbiter #(
  parameter int N_TILES  = 16,
  parameter int LINE_LEN = 64,
  parameter int HART_W   = $clog2(N_TILES)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_TILES-1:0]   req_valid_i,
  input  logic [N_TILES*8-1:0] req_char_i,
  output logic [N_TILES-1:0]   req_ready_o,
  output logic                 out_valid_o,
  output logic [7:0]           out_char_o,
  output logic [HART_W-1:0]    out_hartid_o,
  output logic                 out_sol_o,
  output logic                 out_last_o,
  input  logic                 out_ready_i
`ifdef MAGIA_STDIO_TIMESTAMP_EN
  ,
  output logic [63:0]          out_timestamp_o
`endif
);

  localparam int CNT_W = $clog2(LINE_LEN) + 1;
  localparam int PTR_W = $clog2(LINE_LEN);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t                            state;
  logic [N_TILES-1:0][CNT_W-1:0]     cnt;
  logic [N_TILES-1:0]                pend;
  logic [N_TILES-1:0][7:0]           tile_char;
  logic [HART_W-1:0]                 gnt;
  logic [HART_W-1:0]                 rr_ptr;
  logic [HART_W-1:0]                 pick;
  logic [HART_W:0]                   rr_sum;
  logic [PTR_W-1:0]                  rd_ptr;
  logic [PTR_W-1:0]                  rd_idx;
  logic                              clr;

`ifdef MAGIA_STDIO_TIMESTAMP_EN
  logic [63:0]                       cycle_cnt;
  logic [N_TILES-1:0][63:0]          cap;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cycle_cnt <= '0;
    else         cycle_cnt <= cycle_cnt + 64'd1;
  end
`endif

  assign req_ready_o = ~pend;
  assign clr         = (state == DONE);
  // In IDLE the read port prefetches the first char; in DRAIN it looks one ahead.
  assign rd_idx      = (state == IDLE) ? '0 : rd_ptr + PTR_W'(1);

  // Descending scan so the tile closest to rr_ptr (inclusive, wrapping) wins.
  always_comb begin
    pick   = '0;
    rr_sum = '0;
    for (int k = N_TILES - 1; k >= 0; k--) begin
      rr_sum = {1'b0, rr_ptr} + (HART_W+1)'(k);
      if (rr_sum >= (HART_W+1)'(N_TILES)) rr_sum = rr_sum - (HART_W+1)'(N_TILES);
      if (pend[rr_sum[HART_W-1:0]]) pick = rr_sum[HART_W-1:0];
    end
  end

  for (genvar g = 0; g < N_TILES; g++) begin : g_tile
    logic [7:0] mem [LINE_LEN];

    always_ff @(posedge clk_i) begin
      if (req_valid_i[g] && !pend[g]) mem[cnt[g][PTR_W-1:0]] <= req_char_i[g*8 +: 8];
    end

    assign tile_char[g] = mem[rd_idx];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt  <= '0;
      pend <= '0;
`ifdef MAGIA_STDIO_TIMESTAMP_EN
      cap  <= '0;
`endif
    end else begin
      for (int i = 0; i < N_TILES; i++) begin
        if (clr && gnt == HART_W'(i)) begin
          cnt[i]  <= '0;
          pend[i] <= 1'b0;
        end else if (req_valid_i[i] && !pend[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
          if (req_char_i[i*8 +: 8] == 8'h0A || cnt[i] == CNT_W'(LINE_LEN - 1)) begin
            pend[i] <= 1'b1;
`ifdef MAGIA_STDIO_TIMESTAMP_EN
            cap[i]  <= cycle_cnt;
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      gnt          <= '0;
      rr_ptr       <= '0;
      rd_ptr       <= '0;
      out_valid_o  <= 1'b0;
      out_char_o   <= '0;
      out_hartid_o <= '0;
      out_sol_o    <= 1'b0;
      out_last_o   <= 1'b0;
`ifdef MAGIA_STDIO_TIMESTAMP_EN
      out_timestamp_o <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|pend) begin
            gnt          <= pick;
            rd_ptr       <= '0;
            out_valid_o  <= 1'b1;
            out_char_o   <= tile_char[pick];
            out_hartid_o <= pick;
            out_sol_o    <= 1'b1;
            out_last_o   <= (cnt[pick] == CNT_W'(1));
`ifdef MAGIA_STDIO_TIMESTAMP_EN
            out_timestamp_o <= cap[pick];
`endif
            state        <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready_i) begin
            if (out_last_o) begin
              out_valid_o <= 1'b0;
              out_sol_o   <= 1'b0;
              out_last_o  <= 1'b0;
              state       <= DONE;
            end else begin
              rd_ptr     <= rd_ptr + PTR_W'(1);
              out_char_o <= tile_char[gnt];
              out_sol_o  <= 1'b0;
              out_last_o <= (({1'b0, rd_ptr} + CNT_W'(2)) == cnt[gnt]);
            end
          end
        end
        DONE: begin
          rr_ptr <= (gnt == HART_W'(N_TILES - 1)) ? '0 : gnt + HART_W'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_magia_stdio_arbiter.sv
// Scoreboard bench for magia_stdio_arbiter: directed scenarios plus random
// simultaneous-line rounds checked against a round-robin line model.
module tb_magia_stdio_arbiter;
  localparam int N = 16;
  localparam int L = 64;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_char;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [7:0]     out_char;
  logic [3:0]     out_hartid;
  logic           out_sol;
  logic           out_last;
  logic           out_ready;

  magia_stdio_arbiter #(.N_TILES(N), .LINE_LEN(L)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_char_i   (req_char),
    .req_ready_o  (req_ready),
    .out_valid_o  (out_valid),
    .out_char_o   (out_char),
    .out_hartid_o (out_hartid),
    .out_sol_o    (out_sol),
    .out_last_o   (out_last),
    .out_ready_i  (out_ready)
  );

  typedef struct {
    logic [3:0] hart;
    logic [7:0] ch;
    logic       sol;
    logic       last;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] line_buf [N][L];
  int         line_len [N];
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_hs_cyc = 0;
  int         ready_mode = 0;
  int         rr = 0;
  logic       stalled = 1'b0;
  logic [13:0] held = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on every handshake, checks hold while stalled.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_hold", 32'({out_char, out_hartid, out_sol, out_last}), 32'(held));
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_char: got 0x%0h from hart %0d, want no output (cycle %0d)",
                     out_char, out_hartid, cyc);
          end else begin
            mon_e = sb.pop_front();
            check("out_char", 32'(out_char), 32'(mon_e.ch));
            check("out_hartid", 32'(out_hartid), 32'(mon_e.hart));
            check("out_sol", 32'(out_sol), 32'(mon_e.sol));
            check("out_last", 32'(out_last), 32'(mon_e.last));
          end
          if (out_last) last_hs_cyc = cyc;
        end else begin
          stalled = 1'b1;
          held    = {out_char, out_hartid, out_sol, out_last};
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input int h);
    for (int p = 0; p < line_len[h]; p++) begin
      exp_t e;
      e.hart = 4'(h);
      e.ch   = line_buf[h][p];
      e.sol  = (p == 0);
      e.last = (p == line_len[h] - 1);
      sb.push_back(e);
    end
  endtask

  task automatic set_str(input int h, input string s);
    line_len[h] = s.len();
    for (int p = 0; p < s.len(); p++) line_buf[h][p] = s[p];
  endtask

  task automatic rand_line(input int h);
    int k;
    if ($urandom_range(0, 7) == 0) begin
      line_len[h] = L;
      for (int p = 0; p < L; p++) line_buf[h][p] = 8'($urandom_range(32, 126));
    end else begin
      k = $urandom_range(0, 12);
      line_len[h] = k + 1;
      for (int p = 0; p < k; p++) line_buf[h][p] = 8'($urandom_range(32, 126));
      line_buf[h][k] = 8'h0A;
    end
  endtask

  task automatic wait_drain;
    for (int k = 0; k < 5000 && sb.size() != 0; k++) tick();
    check("drain_done", 32'(sb.size()), 32'd0);
    tick();
    tick();
  endtask

  // All tiles in 'set' finish their lines in the same cycle; expected order is
  // round-robin from the model pointer.
  task automatic run_round(input logic [N-1:0] set);
    int h;
    int pos;
    int lmax;
    int first;
    int last_h;
    lmax   = 0;
    first  = -1;
    last_h = 0;
    for (int i = 0; i < N; i++)
      if (set[i] && line_len[i] > lmax) lmax = line_len[i];
    for (int k = 0; k < N; k++) begin
      h = (rr + k) % N;
      if (set[h]) begin
        push_line(h);
        if (first < 0) first = h;
        last_h = h;
      end
    end
    rr = (last_h + 1) % N;
    for (int c = 0; c < lmax; c++) begin
      for (int i = 0; i < N; i++) begin
        if (set[i]) begin
          pos = c - (lmax - line_len[i]);
          req_valid[i] = (pos >= 0);
          if (pos >= 0) req_char[i*8 +: 8] = line_buf[i][pos];
        end
      end
      tick();
    end
    req_valid = '0;
    check("ready_low_after_line", 32'(req_ready & set), 32'd0);
    check("valid_before_grant", 32'(out_valid), 32'd0);
    tick();
    check("valid_at_grant", 32'(out_valid), 32'd1);
    check("first_hart", 32'(out_hartid), 32'(first));
    wait_drain();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] set;
    rst_n     = 1'b0;
    req_valid = '0;
    req_char  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) line_len[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0000_FFFF);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_char", 32'(out_char), 32'd0);
    check("rst_out_hartid", 32'(out_hartid), 32'd0);
    check("rst_out_sol", 32'(out_sol), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_ready", 32'(req_ready), 32'h0000_FFFF);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // Single tile
    set_str(3, "hi\n");
    run_round(16'h0008);

    // Bring the pointer to 0, then a simultaneous round; then pointer 1
    set_str(15, "a\n");
    run_round(16'h8000);
    set_str(0, "a\n"); set_str(5, "a\n"); set_str(15, "a\n");
    run_round(16'h8021);
    set_str(0, "b\n");
    run_round(16'h0001);
    set_str(0, "a\n"); set_str(5, "a\n"); set_str(15, "a\n");
    run_round(16'h8021);

    // Back-pressure on tile 2
    set_str(2, "abc\n");
    push_line(2);
    rr = 3;
    for (int p = 0; p < 4; p++) begin
      req_valid[2] = 1'b1;
      req_char[2*8 +: 8] = line_buf[2][p];
      tick();
    end
    req_char[2*8 +: 8] = 8'h78;
    check("bp_ready_low", 32'(req_ready[2]), 32'd0);
    for (int k = 0; k < 500 && !req_ready[2]; k++) tick();
    check("bp_ready_rise", 32'(cyc - last_hs_cyc), 32'd2);
    set_str(2, "x\n");
    push_line(2);
    tick();
    req_char[2*8 +: 8] = 8'h0A;
    tick();
    req_valid[2] = 1'b0;
    wait_drain();

    // Forced flush on tile 1
    for (int p = 0; p < L; p++) line_buf[1][p] = 8'h41;
    line_len[1] = L;
    push_line(1);
    set_str(1, "A\n");
    push_line(1);
    rr = 2;
    req_valid[1] = 1'b1;
    req_char[1*8 +: 8] = 8'h41;
    repeat (L) tick();
    check("flush_ready_low", 32'(req_ready[1]), 32'd0);
    for (int k = 0; k < 500 && !req_ready[1]; k++) tick();
    check("flush_ready_rise", 32'(cyc - last_hs_cyc), 32'd2);
    tick();
    req_char[1*8 +: 8] = 8'h0A;
    tick();
    req_valid[1] = 1'b0;
    wait_drain();

    // Output stall, toggling ready
    ready_mode = 1;
    set_str(6, "xyz\n");
    run_round(16'h0040);

    // Random simultaneous rounds with random consumer back-pressure
    ready_mode = 2;
    for (int r = 0; r < 25; r++) begin
      set = N'($urandom);
      if (set == '0) set = N'(1);
      for (int i = 0; i < N; i++) if (set[i]) rand_line(i);
      run_round(set);
    end
    ready_mode = 0;
    tick();
    tick();

    // Reset while the second character is on the output
    set_str(4, "pqrs\n");
    push_line(4);
    for (int p = 0; p < 5; p++) begin
      req_valid[4] = 1'b1;
      req_char[4*8 +: 8] = line_buf[4][p];
      tick();
    end
    req_valid[4] = 1'b0;
    tick();
    check("rst_test_first", 32'(out_char), 32'h70);
    tick();
    check("rst_test_second", 32'(out_char), 32'h71);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'h0000_FFFF);
    sb.delete();
    rr = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    set_str(9, "z\n");
    run_round(16'h0200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
